freq_phase_conv: RTL and testbench

- Converts the 32-bit receive and transmit frequencies (Hz) produced by the I2C slave control block into 32-bit NCO phase increments for the DDC/DUC.
- Result per channel: phase = floor(freq * 2^32 / FS_HZ).
- Runs in the I2C control clock domain and consumes its rx_freq/tx_freq outputs directly.
- One shared sequential restoring divider serves both channels; each result is presented with a one-cycle update strobe for the downstream CDC into the NCO domain.

---
 rtl/freq_phase_conv.sv | 199 +++++++++++++++++++
 tb/tb_freq_phase_conv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_phase_conv.sv
// freq_phase_conv
//   Turns the receive/transmit frequencies (Hz) from the I2C control block
//   into 32-bit NCO phase increments: phase = floor(freq * 2^32 / FS_HZ).
//   A single restoring divider, one quotient bit per clock, is shared by
//   both channels. Each new result is announced by a one-cycle strobe so the
//   NCO-side CDC can capture it.
//
// Ports
//   clock     block clock (I2C control domain)
//   _reset    synchronous active-low reset
//   rx_freq   receive frequency, Hz
//   tx_freq   transmit frequency, Hz
//   rx_phase  receive phase increment
//   tx_phase  transmit phase increment
//   rx_stb    rx_phase updated this cycle
//   tx_stb    tx_phase updated this cycle
//   rx_err    last rx request was >= FS_HZ
//   tx_err    last tx request was >= FS_HZ
//   busy      divider running
module freq_phase_conv #(
  parameter logic [31:0] FS_HZ = 32'd122_880_000
) (
  input  logic        clock,
  input  logic        _reset,
  input  logic [31:0] rx_freq,
  input  logic [31:0] tx_freq,
  output logic [31:0] rx_phase,
  output logic [31:0] tx_phase,
  output logic        rx_stb,
  output logic        tx_stb,
  output logic        rx_err,
  output logic        tx_err,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_rx_last;
  logic [DATA_W-1:0]   r_tx_last;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quot;
  logic [4:0]          r_cnt;
  logic                r_sel_tx;       // channel owning the running division
  logic                r_last_served;  // 1: rx was served last, 0: tx (or reset)

  logic                w_rx_pend;
  logic                w_tx_pend;
  logic                w_serve_rx;
  logic                w_serve_tx;
  logic [DATA_W-1:0]   w_sel_freq;
  logic                w_in_range;
  logic [DATA_W:0]     w_div;          // {quotient bit, next remainder}

  // One restoring-division step: shift the remainder left and subtract the
  // divisor when it fits. Because rem < d on entry, the result stays < d.
  function automatic logic [DATA_W:0] div_step(input logic [DATA_W-1:0] rem,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W:0] t;
    logic [DATA_W:0] diff;
    t    = {rem, 1'b0};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d}) begin
      div_step = {1'b1, diff[DATA_W-1:0]};
    end else begin
      div_step = {1'b0, t[DATA_W-1:0]};
    end
  endfunction

  assign w_rx_pend  = (rx_freq != r_rx_last);
  assign w_tx_pend  = (tx_freq != r_tx_last);
  assign w_sel_freq = w_serve_tx ? tx_freq : rx_freq;
  assign w_in_range = (w_sel_freq < FS_HZ);
  assign w_div      = div_step(r_rem, FS_HZ);

  always_ff @(posedge clock) begin
    if (!_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Channel arbitration only happens in IDLE; with both pending the channel
  // not served last wins, which favours rx straight after reset.
  always_comb begin
    w_state_nxt = r_state;
    w_serve_rx  = 1'b0;
    w_serve_tx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_pend && w_tx_pend) begin
          w_serve_tx = r_last_served;
          w_serve_rx = !r_last_served;
        end else begin
          w_serve_rx = w_rx_pend;
          w_serve_tx = w_tx_pend;
        end
        if ((w_serve_rx || w_serve_tx) && w_in_range) begin
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (!_reset) begin
      rx_phase      <= '0;
      tx_phase      <= '0;
      rx_stb        <= 1'b0;
      tx_stb        <= 1'b0;
      rx_err        <= 1'b0;
      tx_err        <= 1'b0;
      busy          <= 1'b0;
      r_rx_last     <= '0;
      r_tx_last     <= '0;
      r_last_served <= 1'b0;
      r_sel_tx      <= 1'b0;
      r_cnt         <= 5'd0;
    end else begin
      rx_stb <= 1'b0;
      tx_stb <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_serve_rx || w_serve_tx) begin
            r_last_served <= w_serve_rx;
            r_sel_tx      <= w_serve_tx;
            // Recording the value now means the same input never retriggers.
            if (w_serve_rx) begin
              r_rx_last <= rx_freq;
            end else begin
              r_tx_last <= tx_freq;
            end
            if (!w_in_range) begin
              if (w_serve_rx) begin
                rx_err <= 1'b1;
              end else begin
                tx_err <= 1'b1;
              end
            end else begin
              r_cnt <= 5'd0;
              busy  <= 1'b1;
            end
          end
        end
        DIV: begin
          r_cnt <= r_cnt + 5'd1;
        end
        DONE: begin
          if (r_sel_tx) begin
            tx_phase <= r_quot;
            tx_stb   <= 1'b1;
            tx_err   <= 1'b0;
          end else begin
            rx_phase <= r_quot;
            rx_stb   <= 1'b1;
            rx_err   <= 1'b0;
          end
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Divider datapath: freq*2^32/FS is formed by feeding the operand in as the
  // starting remainder and shifting in 32 zero bits.
  always_ff @(posedge clock) begin
    case (r_state)
      IDLE: begin
        if ((w_serve_rx || w_serve_tx) && w_in_range) begin
          r_rem  <= w_sel_freq;
          r_quot <= '0;
        end
      end
      DIV: begin
        r_rem  <= w_div[DATA_W-1:0];
        r_quot <= {r_quot[DATA_W-2:0], w_div[DATA_W]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_freq_phase_conv.sv
// tb_freq_phase_conv
//   Directed and randomized checks of freq_phase_conv. Expected phases come
//   from floor(freq * 2^32 / FS) evaluated with 64-bit arithmetic; channel
//   order and held values come from a small model of the arbitration rules.
module tb_freq_phase_conv;

  localparam logic [31:0] FS = 32'd122_880_000;

  logic        clock = 1'b0;
  logic        _reset;
  logic [31:0] rx_freq;
  logic [31:0] tx_freq;
  logic [31:0] rx_phase;
  logic [31:0] tx_phase;
  logic        rx_stb;
  logic        tx_stb;
  logic        rx_err;
  logic        tx_err;
  logic        busy;

  freq_phase_conv #(.FS_HZ(FS)) dut (
    .clock    (clock),
    ._reset   (_reset),
    .rx_freq  (rx_freq),
    .tx_freq  (tx_freq),
    .rx_phase (rx_phase),
    .tx_phase (tx_phase),
    .rx_stb   (rx_stb),
    .tx_stb   (tx_stb),
    .rx_err   (rx_err),
    .tx_err   (tx_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_rx_ph;
  logic [31:0] m_tx_ph;
  bit          m_last_rx;

  function automatic logic [31:0] ref_phase(input logic [31:0] f);
    logic [63:0] num;
    logic [63:0] q;
    num = {f, 32'b0};
    q   = num / {32'b0, FS};
    return q[31:0];
  endfunction

  function automatic logic [31:0] rand_in_range(input logic [31:0] avoid);
    logic [31:0] r;
    do r = $urandom_range(FS - 32'd1, 1); while (r == avoid);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for either strobe; n = negedges until it appeared, -1 if none.
  task automatic wait_any(input int maxc, output int n, output bit ch,
                          output logic [31:0] val, output bit busy_all);
    n = -1; ch = 1'b0; val = '0; busy_all = 1'b1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clock);
      if (rx_stb || tx_stb) begin
        n   = i;
        ch  = tx_stb;
        val = tx_stb ? tx_phase : rx_phase;
        return;
      end
      if (busy !== 1'b1) busy_all = 1'b0;
    end
  endtask

  task automatic expect_strobe(input string tag, input bit exp_ch,
                               input logic [31:0] exp_val, input int exp_n);
    int          n;
    bit          ch;
    bit          ba;
    logic [31:0] val;
    wait_any(80, n, ch, val, ba);
    if (exp_n > 0) check({tag, "_latency"}, 32'(n), 32'(exp_n));
    else           check({tag, "_seen"}, {31'b0, (n > 0)}, 32'd1);
    check({tag, "_channel"}, {31'b0, ch}, {31'b0, exp_ch});
    check({tag, "_phase"}, val, exp_val);
    check({tag, "_busy"}, {31'b0, ba}, 32'd1);
    check({tag, "_err"}, {31'b0, (exp_ch ? tx_err : rx_err)}, 32'd0);
    if (exp_ch) m_tx_ph = exp_val; else m_rx_ph = exp_val;
    m_last_rx = !exp_ch;
  endtask

  task automatic expect_reject(input string tag, input bit sel);
    int          n;
    bit          ch;
    bit          ba;
    logic [31:0] val;
    wait_any(40, n, ch, val, ba);
    check({tag, "_no_stb"}, 32'(n), 32'hFFFF_FFFF);
    check({tag, "_err"}, {31'b0, (sel ? tx_err : rx_err)}, 32'd1);
    check({tag, "_held"}, sel ? tx_phase : rx_phase, sel ? m_tx_ph : m_rx_ph);
    m_last_rx = !sel;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_phase"}, rx_phase, 32'd0);
    check({tag, "_tx_phase"}, tx_phase, 32'd0);
    check({tag, "_rx_stb"}, {31'b0, rx_stb}, 32'd0);
    check({tag, "_tx_stb"}, {31'b0, tx_stb}, 32'd0);
    check({tag, "_rx_err"}, {31'b0, rx_err}, 32'd0);
    check({tag, "_tx_err"}, {31'b0, tx_err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // Continuous invariants: phase moves only with its strobe, strobes are
  // single-cycle and never coincide.
  logic        rst_at_edge = 1'b0;
  logic [31:0] prev_rx;
  logic [31:0] prev_tx;
  logic        prev_rx_stb = 1'b0;
  logic        prev_tx_stb = 1'b0;

  always @(posedge clock) rst_at_edge <= _reset;

  always @(negedge clock) begin
    if (rst_at_edge) begin
      if (rx_phase !== prev_rx) check("rx_phase_without_stb", {31'b0, rx_stb}, 32'd1);
      if (tx_phase !== prev_tx) check("tx_phase_without_stb", {31'b0, tx_stb}, 32'd1);
      if (rx_stb || tx_stb) check("stb_exclusive", {31'b0, rx_stb & tx_stb}, 32'd0);
      if (rx_stb) check("rx_stb_one_cycle", {31'b0, prev_rx_stb}, 32'd0);
      if (tx_stb) check("tx_stb_one_cycle", {31'b0, prev_tx_stb}, 32'd0);
    end
    prev_rx     = rx_phase;
    prev_tx     = tx_phase;
    prev_rx_stb = rx_stb;
    prev_tx_stb = tx_stb;
  end

  logic [31:0] bvals [3];
  logic [31:0] evals [2];
  logic [31:0] va;
  logic [31:0] vb;
  bit          sel;
  bit          oor;
  bit          first;

  initial begin
    bvals = '{32'd61_440_000, FS - 32'd1, 32'd1};
    evals = '{FS, 32'hFFFF_FFFF};
    m_rx_ph = '0; m_tx_ph = '0; m_last_rx = 1'b0;

    _reset  = 1'b0;
    rx_freq = 32'd7_000_000;
    tx_freq = 32'd7_000_000;
    repeat (3) @(negedge clock);
    check_zero("reset");

    // Both channels pending at release: rx first, tx 34 cycles later.
    _reset = 1'b1;
    expect_strobe("init_rx", 1'b0, 32'd244_667_733, 34);
    expect_strobe("init_tx", 1'b1, 32'd244_667_733, 34);

    rx_freq = 32'd14_200_000;
    expect_strobe("rx_change", 1'b0, 32'd496_325_973, 34);
    check("rx_change_tx_untouched", tx_phase, 32'd244_667_733);

    for (int i = 0; i < 3; i++) begin
      rx_freq = bvals[i];
      expect_strobe($sformatf("boundary%0d", i), 1'b0, ref_phase(bvals[i]), 34);
    end

    for (int i = 0; i < 2; i++) begin
      rx_freq = evals[i];
      expect_reject($sformatf("range%0d", i), 1'b0);
    end
    rx_freq = 32'd7_000_000;
    expect_strobe("err_clear", 1'b0, 32'd244_667_733, 34);

    rx_freq = 32'd0;
    expect_strobe("zero", 1'b0, 32'd0, 34);

    // Input changes while the divider runs: old result first, then new.
    va = rand_in_range(rx_freq);
    vb = rand_in_range(va);
    rx_freq = va;
    repeat (11) @(negedge clock);
    rx_freq = vb;
    expect_strobe("div_change_old", 1'b0, ref_phase(va), 23);
    expect_strobe("div_change_new", 1'b0, ref_phase(vb), 34);

    // Both channels changed together: round-robin order.
    for (int i = 0; i < 4; i++) begin
      va = rand_in_range(rx_freq);
      vb = rand_in_range(tx_freq);
      rx_freq = va;
      tx_freq = vb;
      first = m_last_rx;
      expect_strobe($sformatf("pair%0d_a", i), first, first ? ref_phase(vb) : ref_phase(va), 34);
      expect_strobe($sformatf("pair%0d_b", i), !first, first ? ref_phase(va) : ref_phase(vb), 34);
    end

    // Random single-channel requests, some out of range.
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(1, 0));
      oor = ($urandom_range(3, 0) == 0);
      do begin
        va = oor ? $urandom_range(32'hFFFF_FFFF, FS) : rand_in_range(32'd0);
      end while (va == (sel ? tx_freq : rx_freq));
      if (sel) tx_freq = va; else rx_freq = va;
      if (oor) expect_reject($sformatf("rand%0d", i), sel);
      else     expect_strobe($sformatf("rand%0d", i), sel, ref_phase(va), 34);
    end

    // Reset in the middle of a division, then reconversion of both inputs.
    vb = rand_in_range(tx_freq);
    tx_freq = vb;
    expect_strobe("pre_reset_tx", 1'b1, ref_phase(vb), 34);
    va = rand_in_range(rx_freq);
    rx_freq = va;
    repeat (21) @(negedge clock);
    _reset = 1'b0;
    @(negedge clock);
    check_zero("mid_div_reset");
    m_rx_ph = '0; m_tx_ph = '0; m_last_rx = 1'b0;
    _reset = 1'b1;
    expect_strobe("post_reset_rx", 1'b0, ref_phase(va), 34);
    expect_strobe("post_reset_tx", 1'b1, ref_phase(vb), 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
